// File: rtl/cs_dequant_sequencer.sv
// Dequantization sequencer: captures one packet, left-shifts one lane per cycle
// through a shared shifter, then holds the rebuilt packet until downstream takes it.
module cs_dequant_sequencer #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 16,
  parameter int SHIFT_W    = 4,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [SHIFT_W-1:0]          bit_shift,
  input  logic [DATA_WIDTH*DEPTH-1:0] y_p,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*DEPTH-1:0] bit_stream,
  output logic                        busy,
  output logic [CNT_W-1:0]            pkt_count
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BUS_W = DATA_WIDTH * DEPTH;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state_q, state_d;
  logic [BUS_W-1:0]      in_buf_q, in_buf_d;
  logic [BUS_W-1:0]      bit_stream_q, bit_stream_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      pkt_count_q, pkt_count_d;
  logic [DATA_WIDTH-1:0] lane_in, lane_out;

  // A logical shift by DATA_WIDTH or more already yields zero, and the result
  // is sized to the lane, so MSBs shifted out are simply dropped.
  assign lane_in  = in_buf_q[idx_q*DATA_WIDTH +: DATA_WIDTH];
  assign lane_out = lane_in << shift_q;

  always_comb begin
    state_d      = state_q;
    in_buf_d     = in_buf_q;
    bit_stream_d = bit_stream_q;
    shift_d      = shift_q;
    idx_d        = idx_q;
    pkt_count_d  = pkt_count_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          in_buf_d = y_p;
          shift_d  = bit_shift;
          idx_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        bit_stream_d[idx_q*DATA_WIDTH +: DATA_WIDTH] = lane_out;
        if (idx_q == IDX_W'(DEPTH - 1)) state_d = DONE;
        else                            idx_d   = idx_q + IDX_W'(1);
      end
      DONE: begin
        if (out_ready) begin
          pkt_count_d = pkt_count_q + CNT_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      in_buf_q     <= '0;
      bit_stream_q <= '0;
      shift_q      <= '0;
      idx_q        <= '0;
      pkt_count_q  <= '0;
    end else begin
      state_q      <= state_d;
      in_buf_q     <= in_buf_d;
      bit_stream_q <= bit_stream_d;
      shift_q      <= shift_d;
      idx_q        <= idx_d;
      pkt_count_q  <= pkt_count_d;
    end
  end

  // Handshake outputs come from registered state only; no out_ready -> in_ready path.
  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign bit_stream = bit_stream_q;
  assign pkt_count  = pkt_count_q;

endmodule

// File: tb/tb_cs_dequant_sequencer.sv
// Directed bench for cs_dequant_sequencer; a second instance with a 3-bit
// packet counter shares all inputs so counter wrap is reachable quickly.
module tb_cs_dequant_sequencer;
  localparam int DW = 16;
  localparam int DP = 16;
  localparam int BW = DW * DP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [3:0]    bit_shift = '0;
  logic [BW-1:0] y_p = '0;
  logic          in_ready, out_valid, busy;
  logic [BW-1:0] bit_stream;
  logic [15:0]   pkt_count;
  logic          in_ready_w, out_valid_w, busy_w;
  logic [BW-1:0] bit_stream_w;
  logic [2:0]    pkt_count_w;

  int passed = 0;
  int total  = 0;

  cs_dequant_sequencer #(.DATA_WIDTH(DW), .DEPTH(DP), .SHIFT_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .bit_shift(bit_shift), .y_p(y_p), .out_valid(out_valid), .out_ready(out_ready),
    .bit_stream(bit_stream), .busy(busy), .pkt_count(pkt_count));

  cs_dequant_sequencer #(.DATA_WIDTH(DW), .DEPTH(DP), .SHIFT_W(4), .CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w),
    .bit_shift(bit_shift), .y_p(y_p), .out_valid(out_valid_w), .out_ready(out_ready),
    .bit_stream(bit_stream_w), .busy(busy_w), .pkt_count(pkt_count_w));

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for IDLE, offers one packet, returns cycles from accept to out_valid (-1 on timeout).
  task automatic run_pkt(input logic [BW-1:0] y, input logic [3:0] s, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 40) begin tick(); n++; end
    lat = -1;
    if (in_ready) begin
      y_p = y; bit_shift = s; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 0;
      while (!out_valid && n < 40) begin tick(); n++; end
      if (out_valid) lat = n;
    end
  endtask

  task automatic test_reset();
    logic [BW-1:0] y;
    tick(); tick();
    total++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL reset_flags: got %b expected 100", {in_ready, out_valid, busy}); else passed++;
    total++; if (bit_stream !== '0 || pkt_count !== 16'h0) $display("FAIL reset_data: got stream %h count %h expected 0", bit_stream, pkt_count); else passed++;
    rst = 1'b0;
    for (int i = 0; i < DP; i++) y[i*DW +: DW] = 16'h1111;
    y_p = y; bit_shift = 4'd0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    total++; if (busy !== 1'b1 || bit_stream === '0) $display("FAIL midrun_busy: got busy %b stream %h expected busy 1 and partial data", busy, bit_stream); else passed++;
    #3 rst = 1'b1;
    #1;
    total++; if ({in_ready, out_valid, busy} !== 3'b100) $display("FAIL async_reset_flags: got %b expected 100", {in_ready, out_valid, busy}); else passed++;
    total++; if (bit_stream !== '0 || pkt_count !== 16'h0 || pkt_count_w !== 3'd0) $display("FAIL async_reset_data: got stream %h count %h expected 0", bit_stream, pkt_count); else passed++;
    #2 rst = 1'b0;
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL post_reset_idle: got in_ready %b out_valid %b expected 1 0", in_ready, out_valid); else passed++;
  endtask

  task automatic test_basic();
    logic [BW-1:0] y, e;
    int lat;
    for (int i = 0; i < DP; i++) begin
      y[i*DW +: DW] = 16'(i + 1);
      e[i*DW +: DW] = 16'(8 * (i + 1));
    end
    out_ready = 1'b1;
    run_pkt(y, 4'd3, lat);
    total++; if (lat !== 16) $display("FAIL basic_latency: got %0d expected 16", lat); else passed++;
    total++; if (bit_stream !== e) $display("FAIL basic_data: got %h expected %h", bit_stream, e); else passed++;
    total++; if (in_ready !== 1'b0 || pkt_count !== 16'd0) $display("FAIL basic_done_state: got in_ready %b count %0d expected 0 0", in_ready, pkt_count); else passed++;
    tick();
    total++; if (pkt_count !== 16'd1) $display("FAIL basic_count: got %0d expected 1", pkt_count); else passed++;
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL basic_idle_return: got %b expected 100", {in_ready, out_valid, busy}); else passed++;
  endtask

  task automatic test_truncation();
    logic [BW-1:0] y, e;
    int lat;
    for (int i = 0; i < DP; i++) y[i*DW +: DW] = 16'h8001;
    for (int i = 0; i < DP; i++) e[i*DW +: DW] = 16'h0002;
    run_pkt(y, 4'd1, lat);
    total++; if (lat !== 16 || bit_stream !== e) $display("FAIL trunc_msb: got lat %0d data %h expected 16 %h", lat, bit_stream, e); else passed++;
    tick();
    for (int i = 0; i < DP; i++) y[i*DW +: DW] = 16'h0003;
    for (int i = 0; i < DP; i++) e[i*DW +: DW] = 16'h8000;
    run_pkt(y, 4'd15, lat);
    total++; if (lat !== 16 || bit_stream !== e) $display("FAIL trunc_shift15: got lat %0d data %h expected 16 %h", lat, bit_stream, e); else passed++;
    tick();
    for (int i = 0; i < DP; i++) y[i*DW +: DW] = 16'hA5A0 + 16'(i);
    run_pkt(y, 4'd0, lat);
    total++; if (lat !== 16 || bit_stream !== y) $display("FAIL shift_zero: got lat %0d data %h expected 16 %h", lat, bit_stream, y); else passed++;
    tick();
    total++; if (pkt_count !== 16'd4) $display("FAIL trunc_count: got %0d expected 4", pkt_count); else passed++;
  endtask

  task automatic test_stall();
    logic [BW-1:0] y, e, other;
    int lat, bad;
    for (int i = 0; i < DP; i++) begin
      y[i*DW +: DW]     = 16'(i * 16'h0101);
      e[i*DW +: DW]     = 16'(i * 16'h0404);
      other[i*DW +: DW] = 16'hFFFF;
    end
    out_ready = 1'b0;
    run_pkt(y, 4'd2, lat);
    total++; if (lat !== 16 || bit_stream !== e) $display("FAIL stall_entry: got lat %0d data %h expected 16 %h", lat, bit_stream, e); else passed++;
    y_p = other; bit_shift = 4'd7; in_valid = 1'b1;
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || bit_stream !== e || pkt_count !== 16'd4) bad++;
    end
    total++; if (bad !== 0) $display("FAIL stall_hold: got %0d bad cycles expected 0 (last out_valid %b in_ready %b)", bad, out_valid, in_ready); else passed++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    total++; if (pkt_count !== 16'd5 || out_valid !== 1'b0) $display("FAIL stall_release: got count %0d out_valid %b expected 5 0", pkt_count, out_valid); else passed++;
    repeat (3) tick();
    total++; if (pkt_count !== 16'd5 || busy !== 1'b0 || bit_stream !== e) $display("FAIL stall_single_inc: got count %0d busy %b expected 5 0", pkt_count, busy); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] y1, y2, e1, e2;
    int n;
    for (int i = 0; i < DP; i++) begin
      y1[i*DW +: DW] = 16'h0100 + 16'(i);
      e1[i*DW +: DW] = 16'h0200 + 16'(2 * i);
      y2[i*DW +: DW] = 16'h0010 + 16'(i);
      e2[i*DW +: DW] = 16'h0100 + 16'(16 * i);
    end
    out_ready = 1'b1;
    y_p = y1; bit_shift = 4'd1; in_valid = 1'b1;
    tick();
    y_p = y2; bit_shift = 4'd4;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    total++; if (n !== 16 || bit_stream !== e1) $display("FAIL b2b_first: got lat %0d data %h expected 16 %h", n, bit_stream, e1); else passed++;
    tick();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || pkt_count !== 16'd6) $display("FAIL b2b_idle: got in_ready %b out_valid %b count %0d expected 1 0 6", in_ready, out_valid, pkt_count); else passed++;
    tick();
    total++; if (in_ready !== 1'b0 || busy !== 1'b1) $display("FAIL b2b_second_accept: got in_ready %b busy %b expected 0 1", in_ready, busy); else passed++;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin tick(); n++; end
    total++; if (n !== 16 || bit_stream !== e2) $display("FAIL b2b_second: got lat %0d data %h expected 16 %h", n, bit_stream, e2); else passed++;
    tick();
    total++; if (pkt_count !== 16'd7 || pkt_count_w !== 3'd7) $display("FAIL b2b_count: got %0d/%0d expected 7/7", pkt_count, pkt_count_w); else passed++;
  endtask

  task automatic test_wrap();
    logic [BW-1:0] y;
    int lat;
    for (int i = 0; i < DP; i++) y[i*DW +: DW] = 16'(i);
    out_ready = 1'b1;
    run_pkt(y, 4'd0, lat);
    total++; if (lat !== 16) $display("FAIL wrap_latency: got %0d expected 16", lat); else passed++;
    tick();
    total++; if (pkt_count_w !== 3'd0) $display("FAIL wrap_small_counter: got %0d expected 0", pkt_count_w); else passed++;
    total++; if (pkt_count !== 16'd8) $display("FAIL wrap_main_counter: got %0d expected 8", pkt_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_truncation();
    test_stall();
    test_back_to_back();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish within 200000");
    $fatal(1);
  end
endmodule
